// File: rtl/header_parser_n_pkg.sv
// Shared definitions for the RX frame header parser.
// State encodings, default packet-type codes and the entry marker bit.
package header_parser_n_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [7:0] FRAG_CODE_DEF  = 8'hFF;
  localparam logic [7:0] EMPTY_CODE_DEF = 8'h00;

  // The marker sits just above the payload bits of a buffer entry.
  function automatic int marker_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/header_parser_n.sv
// Walks an RX buffer frame from its tail, captures the header bytes,
// counts consumed payload and releases the frame when it ends.
module header_parser_n
  import header_parser_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int HDR_BYTES = 2,
  parameter logic [DATA_W-1:0] FRAG_CODE = FRAG_CODE_DEF,
  parameter logic [DATA_W-1:0] EMPTY_CODE = EMPTY_CODE_DEF,
  parameter int CNT_W = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W:0]             in_frame_data,
  input  logic                        in_frame_valid,
  input  logic [ADDR_W-1:0]           in_frame_tail,
  input  logic                        in_frame_next,
  output logic [ADDR_W-1:0]           in_frame_addr,
  output logic                        in_frame_latch_tail,
  output logic [HDR_BYTES*DATA_W-1:0] header_bytes,
  output logic [DATA_W-1:0]           header_eid,
  output logic                        header_done,
  output logic                        packet_is_empty,
  output logic                        is_fragment,
  output logic                        header_error,
  output logic [CNT_W-1:0]            payload_count,
  input  logic                        header_done_clear,
  input  logic                        error_clear
);

  localparam int MK = marker_bit(DATA_W);
  localparam int IDX_W = $clog2(HDR_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_BYTES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] hdr_q [HDR_BYTES];

  logic              data_ok;
  logic              abort;
  logic              frame_end;
  logic              last;
  logic [DATA_W-1:0] byte_in;
  logic [DATA_W-1:0] byte1;

  assign data_ok   = ~in_frame_data[MK];
  assign byte_in   = in_frame_data[DATA_W-1:0];
  assign in_frame_addr = in_frame_tail + offset;
  assign abort     = (state == ST_HDR) && !in_frame_valid;
  assign frame_end = (state == ST_WAIT) && !in_frame_valid;
  assign in_frame_latch_tail = !rst && (abort || frame_end);
  assign last      = (idx == IDX_LAST);

  // Byte1 may be arriving this cycle (2-byte header) or already stored.
  assign byte1 = (idx == IDX_W'(1)) ? byte_in : hdr_q[1];

  for (genvar g = 0; g < HDR_BYTES; g++) begin : g_pack
    assign header_bytes[g*DATA_W +: DATA_W] = hdr_q[g];
  end

  assign header_eid = hdr_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      offset          <= '0;
      idx             <= '0;
      header_done     <= 1'b0;
      is_fragment     <= 1'b0;
      packet_is_empty <= 1'b0;
      header_error    <= 1'b0;
      payload_count   <= '0;
      for (int i = 0; i < HDR_BYTES; i++) begin
        hdr_q[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          offset <= '0;
          if (in_frame_valid) begin
            offset        <= ADDR_W'(1);
            idx           <= '0;
            payload_count <= '0;
            state         <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!in_frame_valid) begin
            offset <= '0;
            state  <= ST_IDLE;
          end else if (data_ok) begin
            hdr_q[idx] <= byte_in;
            offset     <= offset + ADDR_W'(1);
            idx        <= idx + IDX_W'(1);
            if (last) begin
              header_done     <= 1'b1;
              is_fragment     <= (byte1 == FRAG_CODE);
              packet_is_empty <= (byte1 == EMPTY_CODE);
              state           <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (in_frame_next && (payload_count != '1)) begin
            payload_count <= payload_count + CNT_W'(1);
          end
          if (!in_frame_valid) begin
            offset <= '0;
            state  <= ST_IDLE;
          end else if (in_frame_next) begin
            offset <= offset + ADDR_W'(1);
          end
        end
        default: begin
          offset <= '0;
          state  <= ST_IDLE;
        end
      endcase

      if (abort) begin
        header_error <= 1'b1;
      end else if (error_clear) begin
        header_error <= 1'b0;
      end

      // Clearing wins over a same-cycle set above.
      if (header_done_clear || !in_frame_valid) begin
        header_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_header_parser_n.sv
// Randomised bench for header_parser_n: 2-byte and 4-byte header variants
// driven from a shared buffer model, checked against header rules.
module tb_header_parser_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_frame_valid;
  logic        in_frame_next;
  logic        header_done_clear;
  logic        error_clear;
  logic [8:0]  in_frame_tail;
  logic [8:0]  mem [512];

  logic [8:0]  data2, addr2, data4, addr4;
  logic        latch2, done2, empty2, frag2, err2;
  logic        latch4, done4, empty4, frag4, err4;
  logic [15:0] bytes2;
  logic [31:0] bytes4;
  logic [7:0]  eid2, eid4;
  logic [8:0]  cnt2;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign data2 = mem[addr2];
  assign data4 = mem[addr4];

  header_parser_n #(.HDR_BYTES(2)) u2 (
    .clk(clk), .rst(rst),
    .in_frame_data(data2), .in_frame_valid(in_frame_valid),
    .in_frame_tail(in_frame_tail), .in_frame_next(in_frame_next),
    .in_frame_addr(addr2), .in_frame_latch_tail(latch2),
    .header_bytes(bytes2), .header_eid(eid2),
    .header_done(done2), .packet_is_empty(empty2),
    .is_fragment(frag2), .header_error(err2),
    .payload_count(cnt2), .header_done_clear(header_done_clear),
    .error_clear(error_clear)
  );

  header_parser_n #(.HDR_BYTES(4), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst),
    .in_frame_data(data4), .in_frame_valid(in_frame_valid),
    .in_frame_tail(in_frame_tail), .in_frame_next(in_frame_next),
    .in_frame_addr(addr4), .in_frame_latch_tail(latch4),
    .header_bytes(bytes4), .header_eid(eid4),
    .header_done(done4), .packet_is_empty(empty4),
    .is_fragment(frag4), .header_error(err4),
    .payload_count(cnt4), .header_done_clear(header_done_clear),
    .error_clear(error_clear)
  );

  function automatic logic [8:0] g_addr(input int h);
    return (h == 2) ? addr2 : addr4;
  endfunction
  function automatic logic g_done(input int h);
    return (h == 2) ? done2 : done4;
  endfunction
  function automatic logic g_latch(input int h);
    return (h == 2) ? latch2 : latch4;
  endfunction
  function automatic logic g_err(input int h);
    return (h == 2) ? err2 : err4;
  endfunction
  function automatic logic g_frag(input int h);
    return (h == 2) ? frag2 : frag4;
  endfunction
  function automatic logic g_empty(input int h);
    return (h == 2) ? empty2 : empty4;
  endfunction
  function automatic logic [7:0] g_eid(input int h);
    return (h == 2) ? eid2 : eid4;
  endfunction
  function automatic logic [31:0] g_hdr(input int h);
    return (h == 2) ? {16'h0, bytes2} : bytes4;
  endfunction
  function automatic int g_cnt(input int h);
    if (h == 2) return int'(cnt2);
    return int'(cnt4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [8:0] a, input logic [7:0] b);
    mem[a] = {1'b0, b};
  endtask

  task automatic fill_random();
    for (int i = 0; i < 512; i++) mem[i] = {1'b0, 8'($urandom)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_frame_valid = 1'b0;
    in_frame_next = 1'b0;
    header_done_clear = 1'b0;
    error_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full frame: header capture, payload pulses, release; model from buffer contents.
  task automatic run_frame(input int h, input logic [8:0] tail, input int npay);
    logic [31:0] exp_hdr;
    logic [7:0]  b1;
    int          exp_cnt;
    int          cmax;
    exp_hdr = '0;
    for (int i = 0; i < h; i++) exp_hdr[i*8 +: 8] = mem[9'(tail + 9'(i + 1))][7:0];
    b1 = exp_hdr[15:8];
    cmax = (h == 2) ? 511 : 15;
    exp_cnt = (npay > cmax) ? cmax : npay;
    in_frame_tail = tail;
    in_frame_valid = 1'b1;
    #1;
    checks++;
    if (g_addr(h) !== tail) begin
      errors++;
      $display("FAIL start_addr h=%0d got=%h exp=%h", h, g_addr(h), tail);
    end
    for (int c = 0; c <= h; c++) begin
      tick();
      checks++;
      if (g_addr(h) !== 9'(tail + 9'(c + 1))) begin
        errors++;
        $display("FAIL hdr_addr h=%0d c=%0d got=%h exp=%h", h, c, g_addr(h), 9'(tail + 9'(c + 1)));
      end
      checks++;
      if (g_done(h) !== (c == h)) begin
        errors++;
        $display("FAIL done_timing h=%0d c=%0d got=%b exp=%b", h, c, g_done(h), (c == h));
      end
    end
    checks++;
    if (g_hdr(h) !== exp_hdr) begin
      errors++;
      $display("FAIL header_bytes h=%0d got=%h exp=%h", h, g_hdr(h), exp_hdr);
    end
    checks++;
    if (g_eid(h) !== exp_hdr[7:0]) begin
      errors++;
      $display("FAIL eid h=%0d got=%h exp=%h", h, g_eid(h), exp_hdr[7:0]);
    end
    checks++;
    if (g_frag(h) !== (b1 == 8'hFF) || g_empty(h) !== (b1 == 8'h00)) begin
      errors++;
      $display("FAIL type h=%0d got frag=%b empty=%b exp b1=%h", h, g_frag(h), g_empty(h), b1);
    end
    checks++;
    if (g_err(h) !== 1'b0) begin
      errors++;
      $display("FAIL err_clean h=%0d got=%b exp=0", h, g_err(h));
    end
    in_frame_next = 1'b1;
    repeat (npay) tick();
    in_frame_next = 1'b0;
    tick();
    checks++;
    if (g_cnt(h) != exp_cnt) begin
      errors++;
      $display("FAIL payload_count h=%0d got=%0d exp=%0d", h, g_cnt(h), exp_cnt);
    end
    checks++;
    if (g_addr(h) !== 9'(tail + 9'(1 + h + npay))) begin
      errors++;
      $display("FAIL payload_addr h=%0d got=%h exp=%h", h, g_addr(h), 9'(tail + 9'(1 + h + npay)));
    end
    in_frame_valid = 1'b0;
    #1;
    checks++;
    if (g_latch(h) !== 1'b1) begin
      errors++;
      $display("FAIL latch_end h=%0d got=%b exp=1", h, g_latch(h));
    end
    tick();
    checks++;
    if (g_latch(h) !== 1'b0 || g_done(h) !== 1'b0 || g_addr(h) !== tail) begin
      errors++;
      $display("FAIL release h=%0d got latch=%b done=%b addr=%h exp 0 0 %h",
               h, g_latch(h), g_done(h), g_addr(h), tail);
    end
  endtask

  task automatic test_reset();
    in_frame_tail = 9'h123;
    do_reset();
    #1;
    checks++;
    if ({done2, err2, frag2, empty2, latch2} !== 5'b0 || bytes2 !== 16'h0 || cnt2 !== 9'h0) begin
      errors++;
      $display("FAIL reset2 got done=%b err=%b bytes=%h cnt=%0d exp zeros", done2, err2, bytes2, cnt2);
    end
    checks++;
    if ({done4, err4, latch4} !== 3'b0 || bytes4 !== 32'h0 || cnt4 !== 4'h0) begin
      errors++;
      $display("FAIL reset4 got done=%b err=%b bytes=%h cnt=%0d exp zeros", done4, err4, bytes4, cnt4);
    end
    checks++;
    if (addr2 !== 9'h123 || eid2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr got addr=%h eid=%h exp 123 00", addr2, eid2);
    end
  endtask

  task automatic test_basic();
    do_reset();
    fill_random();
    put(9'h1F0, 8'hA5);
    put(9'h1F1, 8'h42);
    put(9'h1F2, 8'h05);
    run_frame(2, 9'h1F0, 5);
  endtask

  task automatic test_codes();
    do_reset();
    fill_random();
    put(9'h041, 8'h11);
    put(9'h042, 8'hFF);
    run_frame(2, 9'h040, 2);
    put(9'h061, 8'h22);
    put(9'h062, 8'h00);
    run_frame(2, 9'h060, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    fill_random();
    run_frame(2, 9'h1FF, 4);
    run_frame(2, 9'h1FE, 3);
  endtask

  task automatic test_hdr4();
    do_reset();
    fill_random();
    put(9'h1FE, 8'hFF);
    run_frame(4, 9'h1FC, 20);
    run_frame(4, 9'(8'($urandom)), 7);
  endtask

  task automatic test_saturate();
    do_reset();
    fill_random();
    run_frame(2, 9'h100, 515);
  endtask

  task automatic test_marker();
    do_reset();
    fill_random();
    in_frame_tail = 9'h0A0;
    put(9'h0A1, 8'h5A);
    mem[9'h0A2] = {1'b1, 8'h33};
    in_frame_valid = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (addr2 !== 9'h0A2 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL marker_hold c=%0d got addr=%h done=%b exp 0a2 0", c, addr2, done2);
      end
    end
    mem[9'h0A2] = {1'b0, 8'h33};
    tick();
    checks++;
    if (done2 !== 1'b1 || bytes2 !== 16'h335A) begin
      errors++;
      $display("FAIL marker_release got done=%b bytes=%h exp 1 335a", done2, bytes2);
    end
    in_frame_valid = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    fill_random();
    in_frame_tail = 9'h080;
    put(9'h081, 8'h3C);
    in_frame_valid = 1'b1;
    tick();
    tick();
    in_frame_valid = 1'b0;
    #1;
    checks++;
    if (latch2 !== 1'b1 || err2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got latch=%b err=%b exp 1 0", latch2, err2);
    end
    tick();
    checks++;
    if (err2 !== 1'b1 || latch2 !== 1'b0 || done2 !== 1'b0 || addr2 !== 9'h080) begin
      errors++;
      $display("FAIL abort_state got err=%b latch=%b done=%b addr=%h exp 1 0 0 080",
               err2, latch2, done2, addr2);
    end
    checks++;
    if (eid2 !== 8'h3C) begin
      errors++;
      $display("FAIL abort_eid got=%h exp=3c", eid2);
    end
    in_frame_valid = 1'b1;
    tick();
    in_frame_valid = 1'b0;
    error_clear = 1'b1;
    tick();
    checks++;
    if (err2 !== 1'b1) begin
      errors++;
      $display("FAIL abort_vs_clear got=%b exp=1", err2);
    end
    tick();
    error_clear = 1'b0;
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got=%b exp=0", err2);
    end
  endtask

  task automatic test_done_clear();
    do_reset();
    fill_random();
    in_frame_tail = 9'h010;
    in_frame_valid = 1'b1;
    tick();
    tick();
    header_done_clear = 1'b1;
    tick();
    header_done_clear = 1'b0;
    checks++;
    if (done2 !== 1'b0 || addr2 !== 9'h013) begin
      errors++;
      $display("FAIL clear_beats_set got done=%b addr=%h exp 0 013", done2, addr2);
    end
    in_frame_valid = 1'b0;
    tick();
    in_frame_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (done2 !== 1'b1) begin
      errors++;
      $display("FAIL done_set got=%b exp=1", done2);
    end
    header_done_clear = 1'b1;
    tick();
    header_done_clear = 1'b0;
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL done_ack got=%b exp=0", done2);
    end
    in_frame_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_random();
    for (int f = 0; f < 8; f++) begin
      logic [8:0] t;
      int sel;
      t = 9'($urandom_range(0, 511));
      sel = $urandom_range(0, 3);
      if (sel == 0) put(9'(t + 9'd2), 8'hFF);
      if (sel == 1) put(9'(t + 9'd2), 8'h00);
      run_frame(2, t, $urandom_range(0, 12));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_codes();
    test_wrap();
    test_hdr4();
    test_saturate();
    test_marker();
    test_abort();
    test_done_clear();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
